// File: rtl/memc_unload_if.sv
// Handshake/data bundle between the systolic array side and the result unload buffer.
interface memc_unload_if #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
);
  logic                              start;
  logic                              en;
  logic signed [DIM-1:0][BITS_C-1:0] Cin;
  logic                              rd;
  logic        [$clog2(DIM)-1:0]     Crow;
  logic signed [DIM-1:0][BITS_C-1:0] Cout;
  logic                              rd_valid;
  logic                              busy;
  logic                              ready;

  modport master (
    output start, en, Cin, rd, Crow,
    input  Cout, rd_valid, busy, ready
  );

  modport slave (
    input  start, en, Cin, rd, Crow,
    output Cout, rd_valid, busy, ready
  );
endinterface

// File: rtl/memc_unload.sv
// Deskews DIM skewed lane outputs of a systolic array into a DIM x DIM tile and
// serves one row per cycle once the tile is complete.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no tile held, waiting for start
// S_CAPTURE | collecting skewed beats, k counts en-high beats 0..2*DIM-2
// S_READY   | full tile held, row reads permitted, start re-arms capture
module memc_unload #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic         clk,
  input  logic         rst,
  memc_unload_if.slave bus
);

  localparam int KW = $clog2(2*DIM-1);
  localparam int RW = $clog2(DIM);
  localparam logic [KW-1:0] K_LAST = KW'(2*DIM-2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_READY
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [BITS_C-1:0] tile_q [DIM][DIM];
  logic [DIM-1:0]  we;
  logic [RW-1:0]   wrow [DIM];
  logic [KW:0]     diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CAPTURE;
          k_d     = '0;
        end
      end
      S_CAPTURE: begin
        // k stops at its last value instead of wrapping
        if (bus.en) begin
          if (k_q == K_LAST) state_d = S_READY;
          else               k_d     = k_q + KW'(1);
        end
      end
      S_READY: begin
        if (bus.start) begin
          state_d = S_CAPTURE;
          k_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane j on beat k carries element (k-j, j) of the tile, if that row exists.
  always_comb begin
    diff = '0;
    for (int j = 0; j < DIM; j++) begin
      we[j]   = 1'b0;
      diff    = {1'b0, k_q} - (KW+1)'(j);
      wrow[j] = diff[RW-1:0];
      if (state_q == S_CAPTURE && bus.en &&
          {1'b0, k_q} >= (KW+1)'(j) && diff < (KW+1)'(DIM))
        we[j] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < DIM; j++) begin
      if (!rst && we[j]) tile_q[wrow[j]][j] <= bus.Cin[j];
    end
  end

  // Writes only happen in S_CAPTURE, so a read on the restart cycle sees old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.Cout     <= '0;
    end else if (bus.rd && state_q == S_READY) begin
      bus.rd_valid <= 1'b1;
      for (int j = 0; j < DIM; j++) bus.Cout[j] <= tile_q[bus.Crow][j];
    end else begin
      bus.rd_valid <= 1'b0;
    end
  end

  assign bus.busy  = (state_q == S_CAPTURE);
  assign bus.ready = (state_q == S_READY);

endmodule

// File: tb/tb_memc_unload.sv
// Self-checking bench for memc_unload: drives skewed beats, models the tile as
// element (r, j) = lane j data on beat r+j, and checks reads and status flags.
module tb_memc_unload;

  localparam int BITS_C = 16;
  localparam int DIM    = 8;
  localparam int RW     = $clog2(DIM);
  localparam int NBEAT  = 2*DIM-1;

  typedef logic [DIM-1:0][BITS_C-1:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  memc_unload_if #(.BITS_C(BITS_C), .DIM(DIM)) bus ();

  memc_unload #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  row_t tile_m [DIM];
  bit   tile_ok = 1'b0;
  row_t last_cout = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start = 1'b0;
    bus.en    = 1'b0;
    bus.rd    = 1'b0;
    bus.Crow  = '0;
    bus.Cin   = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    // reset must win over simultaneous start/en/rd
    bus.start = 1'b1;
    bus.en    = 1'b1;
    bus.rd    = 1'b1;
    bus.Cin   = {DIM{16'h1234}};
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.Cout !== row_t'(0)) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b ready=%b rd_valid=%b Cout=%h, required 0 0 0 0",
               bus.busy, bus.ready, bus.rd_valid, bus.Cout);
    end
    drive_idle();
    rst = 1'b0;
    tile_ok   = 1'b0;
    last_cout = '0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b ready=%b, required 0 0", bus.busy, bus.ready);
    end
  endtask

  task automatic test_idle_read();
    bus.rd   = 1'b1;
    bus.Crow = RW'(3);
    tick();
    bus.rd = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.Cout !== last_cout) begin
      n_bad++;
      $display("FAIL idle_read: rd_valid=%b Cout=%h, required 0 %h", bus.rd_valid, bus.Cout, last_cout);
    end
  endtask

  // mode 0: 16*(k-j)+j pattern with DEAD filler, 1: random, 2: all ones
  task automatic run_capture(input int mode, input int stall_a, input int stall_b, input int stall_len,
                             input int restart_beat, input int abort_beat, input bit rand_rd);
    row_t beats [NBEAT];
    for (int k = 0; k < NBEAT; k++) begin
      for (int j = 0; j < DIM; j++) begin
        case (mode)
          0:       beats[k][j] = (k >= j && k - j < DIM) ? BITS_C'(16*(k-j) + j) : 16'hDEAD;
          1:       beats[k][j] = BITS_C'($urandom);
          default: beats[k][j] = '1;
        endcase
      end
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cap_enter: busy=%b ready=%b, required 1 0", bus.busy, bus.ready);
    end
    for (int k = 0; k < NBEAT; k++) begin
      bus.en    = 1'b1;
      bus.Cin   = beats[k];
      bus.start = (k == restart_beat);
      bus.rd    = rand_rd ? 1'($urandom) : 1'b0;
      bus.Crow  = RW'($urandom);
      if (k == abort_beat) rst = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.en    = 1'b0;
      if (k == abort_beat) begin
        rst       = 1'b0;
        tile_ok   = 1'b0;
        last_cout = '0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.Cout !== row_t'(0)) begin
          n_bad++;
          $display("FAIL abort_state: busy=%b ready=%b rd_valid=%b Cout=%h, required 0 0 0 0",
                   bus.busy, bus.ready, bus.rd_valid, bus.Cout);
        end
        bus.rd   = 1'b1;
        bus.Crow = RW'(3);
        tick();
        bus.rd = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL abort_read: rd_valid=%b, required 0", bus.rd_valid);
        end
        return;
      end
      n_cmp++;
      if (bus.busy !== (k < NBEAT-1) || bus.ready !== (k == NBEAT-1) ||
          bus.rd_valid !== 1'b0 || bus.Cout !== last_cout) begin
        n_bad++;
        $display("FAIL cap_beat%0d: busy=%b ready=%b rd_valid=%b Cout=%h, required %b %b 0 %h",
                 k, bus.busy, bus.ready, bus.rd_valid, bus.Cout, k < NBEAT-1, k == NBEAT-1, last_cout);
      end
      if (k < NBEAT-1 && (k == stall_a || k == stall_b)) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.Cin  = {DIM{16'hBAD0}} ^ row_t'($urandom);
          bus.rd   = rand_rd ? 1'($urandom) : 1'b0;
          bus.Crow = RW'($urandom);
          tick();
          n_cmp++;
          if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cap_stall: busy=%b ready=%b rd_valid=%b, required 1 0 0",
                     bus.busy, bus.ready, bus.rd_valid);
          end
        end
      end
    end
    bus.rd = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++)
        tile_m[r][j] = beats[r+j][j];
    tile_ok = 1'b1;
  endtask

  task automatic read_rows(input bit shuffle);
    int order [DIM];
    for (int i = 0; i < DIM; i++) order[i] = i;
    if (shuffle) begin
      for (int i = DIM-1; i > 0; i--) begin
        int p, t;
        p = $urandom_range(0, i);
        t = order[i];
        order[i] = order[p];
        order[p] = t;
      end
    end
    for (int i = 0; i < DIM; i++) begin
      bus.rd   = 1'b1;
      bus.Crow = RW'(order[i]);
      tick();
      if (tile_ok) last_cout = tile_m[order[i]];
      n_cmp++;
      if (bus.rd_valid !== tile_ok || bus.Cout !== last_cout) begin
        n_bad++;
        $display("FAIL read_row%0d: rd_valid=%b Cout=%h, required %b %h",
                 order[i], bus.rd_valid, bus.Cout, tile_ok, last_cout);
      end
    end
    bus.rd = 1'b0;
    tick();
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.Cout !== last_cout) begin
      n_bad++;
      $display("FAIL read_idle: rd_valid=%b Cout=%h, required 0 %h", bus.rd_valid, bus.Cout, last_cout);
    end
  endtask

  task automatic test_pattern();
    run_capture(0, -1, -1, 0, -1, -1, 1'b0);
    read_rows(1'b0);
  endtask

  task automatic test_stall();
    run_capture(0, 4, 11, 3, -1, -1, 1'b0);
    read_rows(1'b0);
  endtask

  task automatic test_restart_ignored();
    run_capture(0, -1, -1, 0, 6, -1, 1'b1);
    read_rows(1'b1);
  endtask

  task automatic test_rd_start();
    row_t old5;
    old5 = tile_m[5];
    bus.rd    = 1'b1;
    bus.Crow  = RW'(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    last_cout = old5;
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.Cout !== old5 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_start: rd_valid=%b busy=%b Cout=%h, required 1 1 %h",
               bus.rd_valid, bus.busy, bus.Cout, old5);
    end
    bus.Crow = RW'(2);
    tick();
    bus.rd = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.Cout !== old5) begin
      n_bad++;
      $display("FAIL rd_in_capture: rd_valid=%b Cout=%h, required 0 %h", bus.rd_valid, bus.Cout, old5);
    end
    // already in capture with k=0; the start pulse inside run_capture is ignored
    run_capture(1, -1, -1, 0, -1, -1, 1'b0);
    read_rows(1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      run_capture(1, $urandom_range(0, 13), $urandom_range(0, 13), $urandom_range(1, 4), -1, -1, 1'b1);
      read_rows(1'b1);
    end
  endtask

  task automatic test_negative();
    run_capture(2, -1, -1, 0, -1, -1, 1'b0);
    read_rows(1'b0);
    n_cmp++;
    if ($signed(bus.Cout[DIM-1]) !== -16'sd1) begin
      n_bad++;
      $display("FAIL negative_sign: Cout[%0d]=%0d, required -1", DIM-1, $signed(bus.Cout[DIM-1]));
    end
  endtask

  task automatic test_reset_abort();
    run_capture(1, -1, -1, 0, -1, 9, 1'b0);
    read_rows(1'b0);
    run_capture(1, 2, 7, 2, -1, -1, 1'b0);
    read_rows(1'b1);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_idle_read();
    test_pattern();
    test_stall();
    test_restart_ignored();
    test_rd_start();
    test_random();
    test_negative();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
